// File: rtl/control_issue_buffer.sv
// control_issue_buffer
//   Consumer end of the decode bundle. Each accepted instruction is held in a
//   small FIFO and issued to execute over valid/ready. The trap cause is
//   encoded once, at accept time, so the head entry already carries its final
//   prioritised cause. A halt instruction puts the buffer into DRAIN (no more
//   accepts). Once that halt entry issues, the buffer is HALTED until reset.
//   Optional feature macro: ISSUE_BUF_PERF_EN enables the issued/stall
//   performance counters. When it is undefined, both counters read zero.
module control_issue_buffer #(
  parameter int CTRL_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_pc,
  input  logic              in_halt,
  input  logic              in_fault_insn,
  input  logic              in_illegal,
  input  logic              in_breakpoint,
  input  logic              in_ecall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_pc,
  output logic              out_trap,
  output logic [3:0]        out_cause,
  output logic              halted,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // mcause priority: instruction fault > illegal > breakpoint > ecall
  function automatic logic [3:0] encode_cause(input logic fault, input logic ill,
                                              input logic bp, input logic ecall);
    logic [3:0] c;
    if (fault)      c = 4'd1;
    else if (ill)   c = 4'd2;
    else if (bp)    c = 4'd3;
    else if (ecall) c = 4'd11;
    else            c = 4'd0;
    return c;
  endfunction

  state_t            state_r, state_s;
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic [CTRL_W-1:0] ctrl_mem_r  [DEPTH];
  logic [31:0]       pc_mem_r    [DEPTH];
  logic [3:0]        cause_mem_r [DEPTH];
  logic              halt_mem_r  [DEPTH];

  logic [3:0] in_cause_s;
  logic       in_halt_eff_s;
  logic       in_ready_s, out_valid_s;
  logic       push_s, pop_s, flush_s;

  // Accept-side decode: cause encoding and whether this is a real (trap-free) halt
  always_comb begin
    in_cause_s    = encode_cause(in_fault_insn, in_illegal, in_breakpoint, in_ecall);
    in_halt_eff_s = in_halt & (in_cause_s == 4'd0);
    in_ready_s    = (count_r < DEPTH_C) && (state_r == ST_RUN);
    out_valid_s   = (count_r != '0) && (state_r != ST_HALTED);
    push_s        = in_valid & in_ready_s & ~flush;
    pop_s         = out_valid_s & out_ready & ~flush;
    // once halted the buffer is frozen, so flush has no effect there
    flush_s       = flush & (state_r != ST_HALTED);
  end

  // Next-state logic for the RUN / DRAIN / HALTED controller
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (push_s && in_halt_eff_s) state_s = ST_DRAIN;
        else                         state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (flush)                                state_s = ST_RUN;
        else if (pop_s && halt_mem_r[rd_ptr_r])   state_s = ST_HALTED;
        else                                      state_s = ST_DRAIN;
      end
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_RUN;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_RUN;
    else     state_r <= state_s;
  end

  // FIFO pointers and occupancy; flush clears everything and beats push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_s) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written at the tail on every accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem_r[i]  <= '0;
        pc_mem_r[i]    <= 32'h0;
        cause_mem_r[i] <= 4'd0;
        halt_mem_r[i]  <= 1'b0;
      end
    end else if (push_s) begin
      ctrl_mem_r[wr_ptr_r]  <= in_ctrl;
      pc_mem_r[wr_ptr_r]    <= in_pc;
      cause_mem_r[wr_ptr_r] <= in_cause_s;
      halt_mem_r[wr_ptr_r]  <= in_halt_eff_s;
    end
  end

  // Issue side is read straight from the head register, never from the inputs
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_ctrl  = ctrl_mem_r[rd_ptr_r];
  assign out_pc    = pc_mem_r[rd_ptr_r];
  assign out_cause = cause_mem_r[rd_ptr_r];
  assign out_trap  = (cause_mem_r[rd_ptr_r] != 4'd0);
  assign halted    = (state_r == ST_HALTED);

`ifdef ISSUE_BUF_PERF_EN
  logic [31:0] issued_r, stall_r;

  // Saturating issue and back-pressure counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_r <= 32'h0;
      stall_r  <= 32'h0;
    end else begin
      if (pop_s && (issued_r != 32'hFFFF_FFFF)) issued_r <= issued_r + 32'd1;
      if (out_valid_s && !out_ready && (stall_r != 32'hFFFF_FFFF)) stall_r <= stall_r + 32'd1;
    end
  end

  assign perf_issued = issued_r;
  assign perf_stall  = stall_r;
`else
  assign perf_issued = 32'h0;
  assign perf_stall  = 32'h0;
`endif

endmodule
